// File: rtl/led_frame_sequencer.sv
// rtl/led_frame_sequencer.sv - frame scheduler streaming a pixel buffer into the WS2812 led_driver
// Optional double buffering: define LED_SEQ_DBUF_EN.
module led_frame_sequencer #(
  parameter int NUM_LEDS     = 144,
  parameter int FRAME_CYCLES = 450000,
  parameter int AW           = $clog2(NUM_LEDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          commit,
  input  logic          start,
  input  logic          auto_en,
  output logic          drv_ready,
  output logic [23:0]   drv_rgb,
  input  logic          drv_busy,
  input  logic          drv_latched,
  output logic          frame_active,
  output logic          frame_done,
  output logic [15:0]   frame_count
);

  localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX    = TW'(FRAME_CYCLES - 1);
  localparam logic [AW-1:0] LAST    = AW'(NUM_LEDS - 1);
  localparam logic [AW-1:0] LAST_M1 = AW'(NUM_LEDS - 2);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          start_req, auto_req;
  logic [AW-1:0] idx;
  logic          take, rd_en, load_first, advance, finish_word, done_nxt;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data;
  logic          wr_ok;

  assign wr_ok        = wr_en && ({1'b0, wr_addr} < (AW+1)'(NUM_LEDS));
  assign frame_active = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              timer <= '0;
    else if (timer == TMAX)  timer <= '0;
    else                     timer <= timer + TW'(1);
  end

  // Requests are one deep; a new pulse in the accept cycle stays pending for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_req <= 1'b0;
      auto_req  <= 1'b0;
    end else begin
      if (start)     start_req <= 1'b1;
      else if (take) start_req <= 1'b0;
      if (!auto_en)            auto_req <= 1'b0;
      else if (timer == TMAX)  auto_req <= 1'b1;
      else if (take)           auto_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    take        = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = idx;
    load_first  = 1'b0;
    advance     = 1'b0;
    finish_word = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if ((start_req || auto_req) && !drv_busy) begin
          state_nxt = FETCH;
          take      = 1'b1;
          rd_en     = 1'b1;
          rd_addr   = '0;
        end
      end
      FETCH: begin
        state_nxt  = STREAM;
        load_first = 1'b1;
        rd_en      = 1'b1;
        rd_addr    = AW'(1);
      end
      STREAM: begin
        if (drv_latched) begin
          if (idx == LAST) begin
            finish_word = 1'b1;
            state_nxt   = DRAIN;
          end else begin
            advance = 1'b1;
            rd_en   = 1'b1;
            rd_addr = (idx >= LAST_M1) ? LAST : idx + AW'(2);
          end
        end
      end
      DRAIN: begin
        if (!drv_busy) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rd_data always holds the word after the one on drv_rgb, so a latch can advance immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      drv_ready   <= 1'b0;
      drv_rgb     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= done_nxt;
      if (done_nxt)     frame_count <= frame_count + 16'd1;
      if (take)         idx <= '0;
      else if (advance) idx <= idx + AW'(1);
      if (load_first || advance) drv_rgb <= rd_data;
      if (load_first)       drv_ready <= 1'b1;
      else if (finish_word) drv_ready <= 1'b0;
    end
  end

`ifdef LED_SEQ_DBUF_EN
  logic        front, swap_pend, rd_bank;
  logic [23:0] mem [2][NUM_LEDS];

  // The bank being read this cycle is the front bank after any swap taken at frame start.
  assign rd_bank = (take && swap_pend) ? ~front : front;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front     <= 1'b0;
      swap_pend <= 1'b0;
    end else begin
      if (take && swap_pend) front <= ~front;
      if (commit)            swap_pend <= 1'b1;
      else if (take)         swap_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[~rd_bank][wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end
`else
  logic [23:0] mem [NUM_LEDS];
  logic        unused_commit;

  assign unused_commit = commit;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb/tb_led_frame_sequencer.sv - self-checking bench for led_frame_sequencer with a WS2812 driver model
module tb_led_frame_sequencer;
  localparam int NUM = 144;
  localparam int FC  = 1000;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          commit, start, auto_en;
  logic          drv_ready;
  logic [23:0]   drv_rgb;
  logic          drv_busy, drv_latched;
  logic          frame_active, frame_done;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  led_frame_sequencer #(.NUM_LEDS(NUM), .FRAME_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .start(start), .auto_en(auto_en), .drv_ready(drv_ready),
    .drv_rgb(drv_rgb), .drv_busy(drv_busy), .drv_latched(drv_latched),
    .frame_active(frame_active), .frame_done(frame_done), .frame_count(frame_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pixel banks as seen by the host, front bank index, pending swap
  logic [23:0] bank_m [2][NUM];
  int front_m  = 0;
  bit pend_m   = 0;
  int frames_m = 0;

  function automatic int back_bank();
`ifdef LED_SEQ_DBUF_EN
    return 1 - front_m;
`else
    return front_m;
`endif
  endfunction

  // Frame-done monitor
  int cyc = 0;
  int done_cnt = 0;
  int done_t[$];
  always @(negedge clk) begin
    cyc++;
    if (rst_n && frame_done) begin
      done_cnt++;
      done_t.push_back(cyc);
    end
  end

  // Driver model: latches a word every `gap` cycles while ready, stays busy `tail` cycles after the last
  logic busy_int = 1'b0;
  logic force_busy = 1'b0;
  int gap = 40;
  int tail = 20;
  logic [23:0] rx_q[$];
  assign drv_busy = busy_int | force_busy;

  initial begin
    int g = 0;
    int t = 0;
    bit just = 0;
    drv_latched = 1'b0;
    forever begin
      @(negedge clk);
      drv_latched = 1'b0;
      if (!rst_n) begin
        busy_int = 1'b0; g = 0; t = 0; just = 0;
      end else if (just) begin
        just = 0;
        if (!drv_ready) begin
          if (tail > 0) t = tail;
          else busy_int = 1'b0;
        end
      end else if (t > 0) begin
        t--;
        if (t == 0) busy_int = 1'b0;
      end else if (drv_ready) begin
        g++;
        if (g >= gap) begin
          g = 0;
          rx_q.push_back(drv_rgb);
          drv_latched = 1'b1;
          busy_int = 1'b1;
          just = 1;
        end
      end
    end
  end

  task automatic host_write(int a, logic [23:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < NUM) bank_m[back_bank()][a] = d;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
`ifdef LED_SEQ_DBUF_EN
    pend_m = 1;
`endif
  endtask

  task automatic model_start();
    if (pend_m) begin
      front_m = 1 - front_m;
      pend_m  = 0;
    end
    frames_m++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int target, int budget, string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_cnt, target);
  endtask

  task automatic check_frames(string tag, int nfr);
    int bad = 0;
    chk({tag, "_len"}, rx_q.size(), nfr * NUM);
    for (int i = 0; i < nfr * NUM; i++)
      if (i >= rx_q.size() || rx_q[i] !== bank_m[front_m][i % NUM]) bad++;
    chk({tag, "_words"}, bad, 0);
    rx_q.delete();
  endtask

  initial begin
    int base;
    int k0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; start = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", drv_ready, 0);
    chk("rst_active", frame_active, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_rgb", drv_rgb, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed ramp pattern, 40 cycles per word, with start-to-ready latency
    for (int i = 0; i < NUM; i++) host_write(i, {i[7:0], i[7:0], i[7:0]});
    do_commit();
    gap = 40; tail = 20;
    rx_q.delete();
    base = done_cnt;
    pulse_start(); model_start();
    chk("lat_req_cycle", frame_active, 0);
    @(negedge clk);
    chk("lat_fetch_active", frame_active, 1);
    chk("lat_fetch_ready", drv_ready, 0);
    @(negedge clk);
    chk("lat_stream_ready", drv_ready, 1);
    chk("lat_rgb0", drv_rgb, bank_m[front_m][0]);
    wait_done(base + 1, 8000, "ramp_done");
    chk("ramp_count", frame_count, frames_m);
    chk("ramp_ready_low", drv_ready, 0);
    check_frames("ramp", 1);
    repeat (5) @(negedge clk);
    chk("ramp_done_once", done_cnt, base + 1);

    // Randomized content and driver pacing
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NUM; i++) host_write(i, 24'($urandom));
      do_commit();
      gap = $urandom_range(1, 8); tail = $urandom_range(0, 30);
      base = done_cnt;
      pulse_start(); model_start();
      wait_done(base + 1, 3000, "rand_done");
      check_frames("rand", 1);
      chk("rand_count", frame_count, frames_m);
      @(negedge clk);
    end

    // Out-of-range write ignored; start while driver busy waits for busy low
    host_write(NUM, 24'h123456);
    host_write(255, 24'h654321);
    force_busy = 1'b1;
    gap = 3; tail = 10;
    base = done_cnt;
    pulse_start(); model_start();
    repeat (20) @(negedge clk);
    chk("busy_hold_idle", frame_active, 0);
    force_busy = 1'b0;
    @(negedge clk);
    chk("busy_rel_active", frame_active, 1);
    chk("busy_rel_ready", drv_ready, 0);
    @(negedge clk);
    chk("busy_rel_stream", drv_ready, 1);
    wait_done(base + 1, 2000, "oor_done");
    check_frames("oor", 1);

    // Three start pulses during a frame yield exactly one more frame
    gap = 5; tail = 10;
    base = done_cnt;
    @(negedge clk);
    pulse_start(); model_start();
    repeat (50) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      repeat (7) @(negedge clk);
    end
    wait_done(base + 1, 2000, "multi_first");
    model_start();
    wait_done(base + 2, 2000, "multi_second");
    check_frames("multi", 2);
    repeat (3000) @(negedge clk);
    chk("multi_no_extra", done_cnt, base + 2);
    chk("multi_count", frame_count, frames_m);

    // Timer-driven frames: one per FRAME_CYCLES, none once auto_en drops
    gap = 1; tail = 50;
    base = done_cnt;
    k0 = done_t.size();
    auto_en = 1'b1;
    wait_done(base + 5, 6500, "auto_five");
    auto_en = 1'b0;
    for (int k = 0; k < 5; k++) model_start();
    for (int k = 0; k < 4; k++)
      if (k0 + k + 1 < done_t.size()) chk("auto_period", done_t[k0+k+1] - done_t[k0+k], FC);
    check_frames("auto", 5);
    repeat (2500) @(negedge clk);
    chk("auto_off", done_cnt, base + 5);
    chk("auto_count", frame_count, frames_m);

`ifdef LED_SEQ_DBUF_EN
    // Back bank filled without commit stays hidden; commit mid-frame swaps at the next start
    gap = 4; tail = 10;
    for (int i = 0; i < NUM; i++) host_write(i, 24'hFF0000);
    base = done_cnt;
    pulse_start(); model_start();
    repeat (30) @(negedge clk);
    do_commit();
    wait_done(base + 1, 2000, "dbuf_old_done");
    check_frames("dbuf_old", 1);
    @(negedge clk);
    pulse_start(); model_start();
    wait_done(base + 2, 2000, "dbuf_new_done");
    chk("dbuf_new_first", (rx_q.size() > 0) ? rx_q[0] : 24'h0, 24'hFF0000);
    check_frames("dbuf_new", 1);
`endif

    // Asynchronous reset in the middle of a streamed frame
    gap = 5; tail = 10;
    pulse_start();
    repeat (100) @(negedge clk);
    chk("mid_ready_pre", drv_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", drv_ready, 0);
    chk("mid_rst_active", frame_active, 0);
    chk("mid_rst_count", frame_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
